// File: rtl/miriscv_pkg.sv
// Shared constants and types for the miriscv UART transmit path.
package miriscv_pkg;

    localparam int unsigned UART_DATA_W     = 8;
    localparam int unsigned UART_FRAME_BITS = 11;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } uart_tx_state_e;

    function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/miriscv_uart_tx_phy.sv
// 8E1 UART serializer: bit divider, frame FSM, shifter and parity, registered line drive.
module miriscv_uart_tx_phy
    import miriscv_pkg::*;
#(
    parameter int unsigned BIT_DIV = 16
) (
    input  logic                   clk_i,
    input  logic                   arstn_i,
    input  logic                   load_i,
    input  logic [UART_DATA_W-1:0] data_i,
    output logic                   idle_o,
    output logic                   done_o,
    output logic                   uart_tx_o
);

    localparam int unsigned      DIV_W    = $clog2(BIT_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_W - 1);

    uart_tx_state_e         state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [2:0]             bit_q, bit_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic                   bit_end;

    assign bit_end   = (div_q == DIV_LAST);
    assign idle_o    = (state_q == TX_IDLE);
    assign uart_tx_o = tx_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_o  = 1'b0;

        if (state_q != TX_IDLE) begin
            div_d = bit_end ? '0 : div_q + 1'b1;
        end

        case (state_q)
            TX_IDLE: begin
                if (load_i) begin
                    state_d = TX_START;
                    shift_d = data_i;
                    par_d   = even_parity(data_i);
                    div_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                    tx_d    = shift_q[0];
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    // 3-bit counter wraps 7 -> 0 on the way out to PARITY
                    bit_d   = bit_q + 1'b1;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = TX_PARITY;
                        tx_d    = par_q;
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
            TX_PARITY: begin
                if (bit_end) begin
                    state_d = TX_STOP;
                    tx_d    = 1'b1;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    done_o = 1'b1;
                    // Back-to-back frame: next start bit follows the stop bit directly
                    if (load_i) begin
                        state_d = TX_START;
                        shift_d = data_i;
                        par_d   = even_parity(data_i);
                        tx_d    = 1'b0;
                    end else begin
                        state_d = TX_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= TX_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/miriscv_uart_tx_sched.sv
// Message-granular round-robin UART TX sharing with one-byte holding register.
// Optional frame/overflow statistics under MIRISCV_UART_TX_STATS_EN.
module miriscv_uart_tx_sched
    import miriscv_pkg::*;
#(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned BAUDRATE = 6250000
) (
    input  logic                          clk_i,
    input  logic                          arstn_i,
    input  logic [NREQ-1:0]               req_valid_i,
    input  logic [NREQ*UART_DATA_W-1:0]   req_data_i,
    input  logic [NREQ-1:0]               req_last_i,
    output logic [NREQ-1:0]               req_ready_o,
    output logic [NREQ-1:0]               grant_o,
    output logic                          busy_o,
`ifdef MIRISCV_UART_TX_STATS_EN
    output logic [31:0]                   tx_count_o,
    output logic [NREQ-1:0]               ovf_drop_o,
`endif
    output logic                          uart_tx_o
);

    localparam int unsigned BIT_DIV = CLK_FREQ / BAUDRATE;
    localparam int unsigned IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (BIT_DIV < 2) begin : g_bit_div_check
        $error("BIT_DIV (CLK_FREQ/BAUDRATE) must be at least 2");
    end

    logic                   lock_q, lock_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic                   hold_full_q, hold_full_d;
    logic [UART_DATA_W-1:0] hold_data_q, hold_data_d;

    logic                   phy_idle, phy_done;
    logic                   drain, hold_avail;
    logic                   win_found;
    logic [IDX_W-1:0]       win_idx, cand_idx, xfer_idx;
    int unsigned            cand;
    logic                   xfer, xfer_last;

    assign drain      = hold_full_q & (phy_idle | phy_done);
    assign hold_avail = ~hold_full_q | drain;

    // First valid requester at or after the pointer, wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand     = (32'(ptr_q) + i) % NREQ;
            cand_idx = IDX_W'(cand);
            if (!win_found && req_valid_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        grant_o     = '0;
        xfer_idx    = lock_q ? owner_q : win_idx;
        if (lock_q) begin
            req_ready_o[owner_q] = req_valid_i[owner_q] & hold_avail;
            grant_o[owner_q]     = 1'b1;
        end else if (win_found && hold_avail) begin
            req_ready_o[win_idx] = 1'b1;
            grant_o[win_idx]     = 1'b1;
        end
        if (!arstn_i) begin
            req_ready_o = '0;
            grant_o     = '0;
        end
    end

    assign xfer      = |req_ready_o;
    assign xfer_last = req_last_i[xfer_idx];

    always_comb begin
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        lock_d      = lock_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        if (drain) begin
            hold_full_d = 1'b0;
        end
        if (xfer) begin
            hold_full_d = 1'b1;
            hold_data_d = req_data_i[xfer_idx*UART_DATA_W +: UART_DATA_W];
            if (xfer_last) begin
                lock_d = 1'b0;
                ptr_d  = (xfer_idx == IDX_W'(NREQ - 1)) ? '0 : xfer_idx + 1'b1;
            end else begin
                lock_d  = 1'b1;
                owner_d = xfer_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            lock_q      <= 1'b0;
            owner_q     <= '0;
            ptr_q       <= '0;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
        end else begin
            lock_q      <= lock_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
        end
    end

    assign busy_o = hold_full_q | ~phy_idle;

    miriscv_uart_tx_phy #(
        .BIT_DIV (BIT_DIV)
    ) u_phy (
        .clk_i     (clk_i),
        .arstn_i   (arstn_i),
        .load_i    (drain),
        .data_i    (hold_data_q),
        .idle_o    (phy_idle),
        .done_o    (phy_done),
        .uart_tx_o (uart_tx_o)
    );

`ifdef MIRISCV_UART_TX_STATS_EN
    logic [31:0]     tx_count_q;
    logic [NREQ-1:0] ovf_q;
    logic [15:0]     wait_cnt_q [NREQ];

    // Wait counter saturates; the 65536th stalled cycle sets the sticky flag
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            tx_count_q <= '0;
            ovf_q      <= '0;
            for (int i = 0; i < int'(NREQ); i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            if (phy_done) begin
                tx_count_q <= tx_count_q + 32'd1;
            end
            for (int i = 0; i < int'(NREQ); i++) begin
                if (req_valid_i[i] && !req_ready_o[i]) begin
                    if (wait_cnt_q[i] == 16'hFFFF) begin
                        ovf_q[i] <= 1'b1;
                    end else begin
                        wait_cnt_q[i] <= wait_cnt_q[i] + 16'd1;
                    end
                end else begin
                    wait_cnt_q[i] <= '0;
                end
            end
        end
    end

    assign tx_count_o = tx_count_q;
    assign ovf_drop_o = ovf_q;
`endif

endmodule
